// File: rtl/text_console_writer.sv
// ============================================================================
//  Module   : text_console_writer
//  Purpose  : Turns a valid/ready stream of ASCII codes into 80x30 tile RAM
//             writes at a hardware cursor, with row/screen clearing.
//             Optional macro CLEAR_ON_RESET_EN: blank the whole screen after reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module text_console_writer #(
    parameter int         MAX_X      = 80,
    parameter int         MAX_Y      = 30,
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        we,
    output logic [11:0] addr_w,
    output logic [6:0]  din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_ROW    = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

`ifdef CLEAR_ON_RESET_EN
    localparam state_t C_RESET_STATE = CLR_SCREEN;
`else
    localparam state_t C_RESET_STATE = IDLE;
`endif

    localparam logic [6:0] C_X_LAST = 7'(MAX_X - 1);
    localparam logic [4:0] C_Y_LAST = 5'(MAX_Y - 1);

    localparam logic [6:0] C_BS = 7'h08;
    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_FF = 7'h0C;
    localparam logic [6:0] C_CR = 7'h0D;

    state_t      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [6:0]  clr_x_q, clr_x_d;
    logic [4:0]  clr_y_q, clr_y_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [6:0]  din_q, din_d;

    logic        w_accept;
    logic        w_printable;
    logic        w_newline;
    logic [6:0]  w_bs_x;

    assign char_ready  = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign w_accept    = char_valid && char_ready;
    assign w_printable = (char_in >= 7'h20) && (char_in != 7'h7F);
    assign w_bs_x      = cur_x_q - 7'd1;

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        w_newline = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        we_d   = 1'b1;
                        addr_d = {cur_y_q, cur_x_q};
                        din_d  = char_in;
                        if (cur_x_q < C_X_LAST) begin
                            cur_x_d = cur_x_q + 7'd1;
                        end else begin
                            w_newline = 1'b1;
                        end
                    end else begin
                        case (char_in)
                            C_CR: cur_x_d = 7'd0;
                            C_LF: w_newline = 1'b1;
                            C_BS: begin
                                // Backspace never wraps to the previous row.
                                if (cur_x_q != 7'd0) begin
                                    cur_x_d = w_bs_x;
                                    we_d    = 1'b1;
                                    addr_d  = {cur_y_q, w_bs_x};
                                    din_d   = BLANK_CHAR;
                                end
                            end
                            C_FF: begin
                                state_d = CLR_SCREEN;
                                clr_x_d = 7'd0;
                                clr_y_d = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end

                if (w_newline) begin
                    cur_x_d = 7'd0;
                    cur_y_d = (cur_y_q == C_Y_LAST) ? 5'd0 : cur_y_q + 5'd1;
                    clr_x_d = 7'd0;
                    state_d = CLR_ROW;
                end
            end

            CLR_ROW: begin
                we_d   = 1'b1;
                addr_d = {cur_y_q, clr_x_q};
                din_d  = BLANK_CHAR;
                if (clr_x_q == C_X_LAST) begin
                    clr_x_d = 7'd0;
                    state_d = IDLE;
                end else begin
                    clr_x_d = clr_x_q + 7'd1;
                end
            end

            CLR_SCREEN: begin
                we_d   = 1'b1;
                addr_d = {clr_y_q, clr_x_q};
                din_d  = BLANK_CHAR;
                if (clr_x_q == C_X_LAST) begin
                    clr_x_d = 7'd0;
                    if (clr_y_q == C_Y_LAST) begin
                        clr_y_d = 5'd0;
                        cur_x_d = 7'd0;
                        cur_y_d = 5'd0;
                        state_d = IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 5'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 7'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_RESET_STATE;
            cur_x_q <= 7'd0;
            cur_y_q <= 5'd0;
            clr_x_q <= 7'd0;
            clr_y_q <= 5'd0;
            we_q    <= 1'b0;
            addr_q  <= 12'd0;
            din_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign we     = we_q;
    assign addr_w = addr_q;
    assign din    = din_q;
    assign cur_x  = cur_x_q;
    assign cur_y  = cur_y_q;

endmodule

`default_nettype wire
